// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the instruction phase sequencer: state encoding,
// default parameters and a small state classification helper.
package kgp_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_MEM       = 3'd3,
        ST_COMMIT    = 3'd4,
        ST_STEP_WAIT = 3'd5,
        ST_HALTED    = 3'd6,
        ST_FAULT     = 3'd7
    } seq_state_t;

    localparam int MEM_TIMEOUT_DEF = 16;
    localparam int CNT_W_DEF       = 32;

    // States in which an instruction is actually in flight.
    function automatic logic is_active(input seq_state_t s);
        return s inside {ST_FETCH, ST_DECODE, ST_MEM, ST_COMMIT};
    endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control/status bundle between the processor environment and the sequencer.
interface phase_sequencer_if #(
    parameter int CNT_W = kgp_seq_pkg::CNT_W_DEF
);
    logic             run;
    logic             step_mode;
    logic             step_req;
    logic             is_mem_op;
    logic             halt_instr;
    logic             mem_ack;
    logic             fetch_en;
    logic             reg_en;
    logic             pc_en;
    logic             mem_req;
    logic             halted;
    logic             fault;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retired_cnt;

    modport master (
        output run, step_mode, step_req, is_mem_op, halt_instr, mem_ack,
        input  fetch_en, reg_en, pc_en, mem_req, halted, fault,
        input  state_o, cycle_cnt, retired_cnt
    );

    modport slave (
        input  run, step_mode, step_req, is_mem_op, halt_instr, mem_ack,
        output fetch_en, reg_en, pc_en, mem_req, halted, fault,
        output state_o, cycle_cnt, retired_cnt
    );

endinterface

// File: rtl/phase_sequencer_perf_counter.sv
// Enable-gated performance counter; i_sat selects saturation at all-ones
// instead of modulo wrap.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_sat,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_full;

    assign w_full = &r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_en && !(i_sat && w_full)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: replaces the free-running 3-phase clock with
// per-instruction fetch/register/PC enables plus a memory wait state.
module phase_sequencer
    import kgp_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    phase_sequencer_if.slave bus
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [WAIT_W-1:0] r_wait;

    logic w_fetch_en;
    logic w_reg_en;
    logic w_pc_en;
    logic w_mem_req;
    logic w_halted;
    logic w_fault;
    logic w_cyc_en;

    logic [CNT_W-1:0] w_cycle_cnt;
    logic [CNT_W-1:0] w_retired_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counts completed MEM cycles; zero whenever outside MEM so it is clear on entry.
    always_ff @(posedge i_clk) begin
        if (i_rst || r_state != ST_MEM) begin
            r_wait <= '0;
        end else begin
            r_wait <= r_wait + WAIT_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fetch_en  = 1'b0;
        w_reg_en    = 1'b0;
        w_pc_en     = 1'b0;
        w_mem_req   = 1'b0;
        w_halted    = 1'b0;
        w_fault     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.run) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_fetch_en  = 1'b1;
                w_state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                w_reg_en = 1'b1;
                if (bus.halt_instr) begin
                    w_state_nxt = ST_HALTED;
                end else if (bus.is_mem_op) begin
                    w_state_nxt = ST_MEM;
                end else begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_MEM: begin
                // An ack in the final allowed cycle still completes the access.
                w_mem_req = 1'b1;
                if (bus.mem_ack) begin
                    w_state_nxt = ST_COMMIT;
                end else if (r_wait == WAIT_LAST) begin
                    w_state_nxt = ST_FAULT;
                end
            end
            ST_COMMIT: begin
                w_pc_en = 1'b1;
                if (!bus.run) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.step_mode) begin
                    w_state_nxt = ST_STEP_WAIT;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_STEP_WAIT: begin
                if (!bus.run) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.step_req) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_HALTED: begin
                w_halted = 1'b1;
            end
            ST_FAULT: begin
                w_fault = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_cyc_en = is_active(r_state);

    perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (w_cyc_en),
        .i_sat (1'b1),
        .o_cnt (w_cycle_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_retired_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (w_pc_en),
        .i_sat (1'b0),
        .o_cnt (w_retired_cnt)
    );

    assign bus.fetch_en    = w_fetch_en;
    assign bus.reg_en      = w_reg_en;
    assign bus.pc_en       = w_pc_en;
    assign bus.mem_req     = w_mem_req;
    assign bus.halted      = w_halted;
    assign bus.fault       = w_fault;
    assign bus.state_o     = r_state;
    assign bus.cycle_cnt   = w_cycle_cnt;
    assign bus.retired_cnt = w_retired_cnt;

endmodule
